// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard FIFO peripheral.
//   - register offsets within the keyboard window (eab[2:1])
//   - STATUS / CONTROL bit positions
//   - queued key entry width and the bus handshake state type
//   - data_word(): formats a FIFO entry for a DATA read
package kbd_pkg;

  localparam int KBD_ENTRY_W = 10;  // {pressed, extended, scancode[7:0]}

  localparam logic [1:0] KBD_DATA   = 2'd0;
  localparam logic [1:0] KBD_STATUS = 2'd1;
  localparam logic [1:0] KBD_CTRL   = 2'd2;
  localparam logic [1:0] KBD_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 15;
  localparam int ST_FULL      = 14;
  localparam int ST_OVERFLOW  = 13;
  localparam int ST_IRQ_EN    = 12;

  // CONTROL bit positions
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // DATA register view: bit 15 flags a valid entry; an empty FIFO reads 0.
  function automatic logic [15:0] data_word(input logic valid,
                                            input logic [KBD_ENTRY_W-1:0] entry);
    data_word = valid ? {1'b1, 5'b0, entry} : 16'h0000;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   push, wdata       write request and data
//   pop               read-advance request (ignored when empty)
//   flush             empties the FIFO; overrides push and pop
//   rdata             head entry (combinational from the read pointer)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
//   drop              one-cycle pulse when a push is rejected for lack of space
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign drop    = push & ~flush & ~do_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only read through rd_ptr behind count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/kbd_fifo_periph.sv
// kbd_fifo_periph: 68000 bus peripheral queuing ps2 key events for the CPU.
// Ports:
//   clk        CPU clock
//   reset_n    async active-low reset
//   ps2_key    [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   cs         keyboard window select (decoded from eab by the top level)
//   as_n       CPU address strobe
//   rw         1 = read, 0 = write
//   lds_n      lower data strobe (CONTROL writes need it low)
//   addr       register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved
//   din        CPU write data
//   dout       read data, held between bus cycles
//   dtack_n    data transfer acknowledge for this window
//   irq        level interrupt: irq_en & FIFO non-empty, registered
//
// Handshake: a bus cycle starts when cs & !as_n is seen in IDLE. On that
// edge the FSM enters ACK, dout is latched and the side effect (DATA pop or
// CONTROL write) happens exactly once. dtack_n stays low throughout ACK and
// returns high on the edge where as_n rises or cs drops; a new cycle needs
// as_n high for at least one clock.
module kbd_fifo_periph
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic        as_n,
  input  logic        rw,
  input  logic        lds_n,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dtack_n,
  output logic        irq
);

  // Bus handshake state; kept as a named register for observation.
  bus_state_e bus_state;
  bus_state_e bus_state_next;

  logic                   key_tog_q;
  logic                   tog_primed;
  logic                   key_push;

  logic [KBD_ENTRY_W-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  logic                   fifo_drop;
  logic                   fifo_pop;
  logic                   fifo_flush;

  logic                   bus_start;
  logic                   rd_start;
  logic                   ctrl_wr;
  logic [15:0]            rd_mux;

  logic                   irq_en;
  logic                   overflow;

  logic                   unused_din;
  assign unused_din = ^din[15:3];

  // Key capture. The first clock after reset only samples the strobe so a
  // stale toggle level is not mistaken for a new key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_tog_q  <= 1'b0;
      tog_primed <= 1'b0;
    end else begin
      key_tog_q  <= ps2_key[10];
      tog_primed <= 1'b1;
    end
  end

  assign key_push = tog_primed & (ps2_key[10] != key_tog_q);

  sync_fifo #(
    .WIDTH (KBD_ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (key_push),
    .wdata   (ps2_key[9:0]),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  // Bus FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_state <= BUS_IDLE;
    else          bus_state <= bus_state_next;
  end

  always_comb begin
    bus_state_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (cs && !as_n) bus_state_next = BUS_ACK;
      BUS_ACK:  if (as_n || !cs) bus_state_next = BUS_IDLE;
      default:  bus_state_next = BUS_IDLE;
    endcase
  end

  // Straight from the state register, so an async reset releases it at once.
  assign dtack_n = (bus_state != BUS_ACK);

  assign bus_start  = (bus_state == BUS_IDLE) & cs & ~as_n;
  assign rd_start   = bus_start & rw;
  assign ctrl_wr    = bus_start & ~rw & ~lds_n & (addr == KBD_CTRL);
  assign fifo_pop   = rd_start & (addr == KBD_DATA);
  assign fifo_flush = ctrl_wr & din[CTRL_FLUSH];

  // Read data selection
  always_comb begin
    rd_mux = 16'h0000;
    case (addr)
      KBD_DATA: rd_mux = data_word(~fifo_empty, fifo_rdata);
      KBD_STATUS: begin
        rd_mux[ST_NOT_EMPTY] = ~fifo_empty;
        rd_mux[ST_FULL]      = fifo_full;
        rd_mux[ST_OVERFLOW]  = overflow;
        rd_mux[ST_IRQ_EN]    = irq_en;
        rd_mux[7:0]          = 8'(fifo_count);
      end
      KBD_CTRL: rd_mux[CTRL_IRQ_EN] = irq_en;
      default:  rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout     <= 16'h0000;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (rd_start) dout <= rd_mux;
      if (ctrl_wr)  irq_en <= din[CTRL_IRQ_EN];
      // A drop in the same cycle as a clear keeps the flag set.
      if (fifo_drop)                         overflow <= 1'b1;
      else if (ctrl_wr && din[CTRL_CLR_OVF]) overflow <= 1'b0;
      irq <= irq_en & ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_kbd_fifo_periph.sv
module tb_kbd_fifo_periph;
  import kbd_pkg::*;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        cs;
  logic        as_n;
  logic        rw;
  logic        lds_n;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dtack_n;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  kbd_fifo_periph #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .cs      (cs),
    .as_n    (as_n),
    .rw      (rw),
    .lds_n   (lds_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .dtack_n (dtack_n),
    .irq     (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers start and end on a falling edge.
  task automatic bus_idle();
    cs = 1'b0; as_n = 1'b1; rw = 1'b1; lds_n = 1'b1; addr = 2'd0; din = 16'h0;
  endtask

  task automatic toggle_key(input logic [9:0] e);
    ps2_key = {~ps2_key[10], e};
  endtask

  // Push one key, then allow one more clock for irq to follow the count.
  task automatic push_key(input logic [9:0] e);
    toggle_key(e);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic bus_start(input logic r, input logic [1:0] a, input logic [15:0] d,
                           input logic l);
    cs = 1'b1; as_n = 1'b0; rw = r; addr = a; din = d; lds_n = l;
  endtask

  // Waits for dtack_n with a cycle budget; ack latency must be one clock.
  task automatic wait_ack(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dtack_n && k < 8);
    check({name, "_ack_lat"}, 16'(k), 16'd1);
  endtask

  task automatic bus_end(input string name);
    bus_idle();
    @(negedge clk);
    check({name, "_dtack_release"}, {15'b0, dtack_n}, 16'd1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    bus_start(1'b1, a, 16'h0, 1'b0);
    wait_ack("rd");
    d = dout;
    bus_end("rd");
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic l);
    bus_start(1'b0, a, d, l);
    wait_ack("wr");
    bus_end("wr");
  endtask

  task automatic expect_read(input string name, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef enum logic [1:0] {V_KEY, V_RD, V_WR} vop_e;
  typedef struct {
    vop_e        op;
    logic [1:0]  addr;
    logic [15:0] data;     // key entry (low 10 bits) or write data
    logic        lds_n;
    logic [15:0] exp;      // expected read data
    logic        exp_irq;  // irq after the operation settles
  } vec_t;

  localparam int NVEC = 21;
  vec_t vt[NVEC];

  initial begin
    logic [15:0] d;
    int          lows;

    ps2_key = 11'h0;
    bus_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dtack_n", {15'b0, dtack_n}, 16'd1);
    check("reset_dout", dout, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ------------------------------------------------ table-driven basics
    vt[0]  = '{V_KEY, KBD_DATA,   16'h021C, 1'b0, 16'h0000, 1'b0};
    vt[1]  = '{V_KEY, KBD_DATA,   16'h001C, 1'b0, 16'h0000, 1'b0};
    vt[2]  = '{V_KEY, KBD_DATA,   16'h0375, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{V_RD,  KBD_STATUS, 16'h0000, 1'b0, 16'h8003, 1'b0};
    vt[4]  = '{V_RD,  KBD_DATA,   16'h0000, 1'b0, 16'h821C, 1'b0};
    vt[5]  = '{V_RD,  KBD_DATA,   16'h0000, 1'b0, 16'h801C, 1'b0};
    vt[6]  = '{V_RD,  KBD_DATA,   16'h0000, 1'b0, 16'h8375, 1'b0};
    vt[7]  = '{V_RD,  KBD_DATA,   16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[8]  = '{V_RD,  KBD_STATUS, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[9]  = '{V_WR,  KBD_CTRL,   16'h0001, 1'b0, 16'h0000, 1'b0};
    vt[10] = '{V_RD,  KBD_CTRL,   16'h0000, 1'b0, 16'h0001, 1'b0};
    vt[11] = '{V_RD,  KBD_RSVD,   16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[12] = '{V_KEY, KBD_DATA,   16'h025A, 1'b0, 16'h0000, 1'b1};
    vt[13] = '{V_RD,  KBD_STATUS, 16'h0000, 1'b0, 16'h9001, 1'b1};
    vt[14] = '{V_RD,  KBD_DATA,   16'h0000, 1'b0, 16'h825A, 1'b0};
    vt[15] = '{V_WR,  KBD_CTRL,   16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[16] = '{V_RD,  KBD_CTRL,   16'h0000, 1'b0, 16'h0001, 1'b0};
    vt[17] = '{V_WR,  KBD_RSVD,   16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vt[18] = '{V_RD,  KBD_CTRL,   16'h0000, 1'b0, 16'h0001, 1'b0};
    vt[19] = '{V_WR,  KBD_CTRL,   16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[20] = '{V_RD,  KBD_CTRL,   16'h0000, 1'b0, 16'h0000, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      case (vt[i].op)
        V_KEY: push_key(vt[i].data[9:0]);
        V_RD: begin
          bus_read(vt[i].addr, d);
          check($sformatf("vec%0d_rd", i), d, vt[i].exp);
        end
        default: bus_write(vt[i].addr, vt[i].data, vt[i].lds_n);
      endcase
      check($sformatf("vec%0d_irq", i), {15'b0, irq}, {15'b0, vt[i].exp_irq});
    end

    // ------------------------------------------------ held as_n: one pop
    push_key(10'h211);
    push_key(10'h122);
    bus_start(1'b1, KBD_DATA, 16'h0, 1'b0);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!dtack_n) lows++;
    end
    check("held_dtack_low_clks", 16'(lows), 16'd20);
    check("held_dout", dout, 16'h8211);
    bus_end("held");
    expect_read("held_status", KBD_STATUS, 16'h8001);
    expect_read("held_next", KBD_DATA, 16'h8122);

    // ------------------------------------------------ push and pop of last entry together
    push_key(10'h233);
    toggle_key(10'h044);
    bus_start(1'b1, KBD_DATA, 16'h0, 1'b0);
    wait_ack("pp");
    check("pp_old_entry", dout, 16'h8233);
    bus_end("pp");
    expect_read("pp_status", KBD_STATUS, 16'h8001);
    expect_read("pp_new_entry", KBD_DATA, 16'h8044);
    expect_read("pp_empty", KBD_STATUS, 16'h0000);

    // ------------------------------------------------ push while full with pop
    for (int i = 0; i < DEPTH; i++) push_key(10'(i));
    toggle_key(10'h2FF);
    bus_start(1'b1, KBD_DATA, 16'h0, 1'b0);
    wait_ack("fp");
    check("fp_head", dout, 16'h8000);
    bus_end("fp");
    expect_read("fp_status", KBD_STATUS, 16'hC010);
    bus_write(KBD_CTRL, 16'h0002, 1'b0);
    expect_read("fp_flushed", KBD_STATUS, 16'h0000);

    // ------------------------------------------------ overflow, scoreboard
    for (int i = 0; i < DEPTH + 2; i++) begin
      logic [9:0] e;
      e = {1'(i), 1'b0, 8'(8'h40 + i)};
      push_key(e);
      if (i < DEPTH) exp_q.push_back({6'b100000, e});
    end
    expect_read("ovf_status", KBD_STATUS, 16'hE010);
    while (exp_q.size() > 0) begin
      logic [15:0] exp;
      exp = exp_q.pop_front();
      expect_read("ovf_entry", KBD_DATA, exp);
    end
    expect_read("ovf_sticky", KBD_STATUS, 16'h2000);
    bus_write(KBD_CTRL, 16'h0004, 1'b0);
    expect_read("ovf_cleared", KBD_STATUS, 16'h0000);

    // ------------------------------------------------ flush same cycle as push
    push_key(10'h101);
    toggle_key(10'h102);
    bus_start(1'b0, KBD_CTRL, 16'h0002, 1'b0);
    wait_ack("fl");
    bus_end("fl");
    expect_read("flush_push_status", KBD_STATUS, 16'h0000);

    // ------------------------------------------------ irq timing
    bus_write(KBD_CTRL, 16'h0001, 1'b0);
    toggle_key(10'h3AB);
    @(negedge clk);
    check("irq_push_plus0", {15'b0, irq}, 16'd0);
    @(negedge clk);
    check("irq_push_plus1", {15'b0, irq}, 16'd1);
    bus_start(1'b1, KBD_DATA, 16'h0, 1'b0);
    @(negedge clk);
    check("irq_pop_plus0", {15'b0, irq}, 16'd1);
    check("irq_pop_data", dout, 16'h83AB);
    bus_idle();
    @(negedge clk);
    check("irq_pop_plus1", {15'b0, irq}, 16'd0);

    // ------------------------------------------------ reset during ACK
    for (int i = 0; i < 5; i++) push_key(10'(10'h050 + i));
    expect_read("rst_pre_status", KBD_STATUS, 16'h9005);
    check("rst_pre_irq", {15'b0, irq}, 16'd1);
    bus_start(1'b1, KBD_DATA, 16'h0, 1'b0);
    wait_ack("rst");
    #2 reset_n = 1'b0;
    #1 check("rst_async_dtack", {15'b0, dtack_n}, 16'd1);
    check("rst_async_irq", {15'b0, irq}, 16'd0);
    @(negedge clk);
    bus_idle();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_read("rst_status", KBD_STATUS, 16'h0000);
    bus_write(KBD_CTRL, 16'h0001, 1'b1);
    expect_read("lds_ignored", KBD_CTRL, 16'h0000);
    check("rst_final_irq", {15'b0, irq}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
